// File: rtl/countcap_if.sv
// rtl/countcap_if.sv - Wishbone-classic bus bundle for the countcap peripheral
// Signal names follow the slave's point of view:
//   cyc_i, stb_i, we_i : cycle, strobe, write enable (master -> slave)
//   adr_i[3:0]         : word address (master -> slave)
//   dat_i[31:0]        : write data (master -> slave)
//   dat_o[31:0]        : read data (slave -> master)
//   ack_o              : acknowledge (slave -> master)
interface countcap_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/countcap.sv
// rtl/countcap.sv - per-channel rising-edge period measurement, Wishbone slave
// Ports:
//   clk_i          : system clock
//   rst_i          : asynchronous active-low reset
//   wb             : Wishbone-classic slave (countcap_if.slave)
//   capture_i[NCH] : asynchronous capture inputs
//   irq_o          : level interrupt, high while any enabled valid flag is set
module countcap #(
  parameter int NCH = 8,
  parameter int CW  = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  countcap_if.slave       wb,
  input  logic [NCH-1:0]  capture_i,
  output logic            irq_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [NCH-1:0] sync1_q, sync2_q, sync3_q;
  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] ien_q, ien_d;
  logic [NCH-1:0] valid_q, valid_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [NCH-1:0] armed_q, armed_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [CW-1:0]  per_q [NCH];
  logic [CW-1:0]  per_d [NCH];
  logic           ack_q;
  logic [31:0]    dat_q, dat_d;
  logic           irq_q;

  logic           access;
  logic           wr_en;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] cap_set, ovf_set;
  logic [NCH-1:0] clr_valid, clr_ovf;
  logic [31:0]    status;
  logic           unused_dat;

  // ack_q in the term forces an idle cycle between back-to-back acks.
  assign access     = wb.cyc_i & wb.stb_i & ~ack_q;
  assign wr_en      = access & wb.we_i;
  assign rise       = sync2_q & ~sync3_q;
  assign status     = 32'(valid_q) | (32'(ovf_q) << 8);
  assign unused_dat = ^wb.dat_i;

  // Channel state machines: idle when disabled, wait for an arming edge,
  // then count and capture on each subsequent edge.
  always_comb begin
    cap_set = '0;
    ovf_set = '0;
    armed_d = armed_q;
    for (int n = 0; n < NCH; n++) begin
      cnt_d[n] = cnt_q[n];
      per_d[n] = per_q[n];
      if (!en_q[n]) begin
        cnt_d[n]   = '0;
        armed_d[n] = 1'b0;
      end else if (!armed_q[n]) begin
        cnt_d[n]   = '0;
        armed_d[n] = rise[n];
      end else if (rise[n]) begin
        cap_set[n] = 1'b1;
        cnt_d[n]   = '0;
        // A saturated counter means the true period is unrepresentable.
        if (cnt_q[n] != CNT_MAX) begin
          per_d[n] = cnt_q[n] + CNT_ONE;
        end else begin
          per_d[n]   = CNT_MAX;
          ovf_set[n] = 1'b1;
        end
      end else if (cnt_q[n] != CNT_MAX) begin
        cnt_d[n] = cnt_q[n] + CNT_ONE;
      end
    end
  end

  // Register writes; captures are OR-ed in after the W1C so they win.
  always_comb begin
    en_d      = en_q;
    ien_d     = ien_q;
    clr_valid = '0;
    clr_ovf   = '0;
    if (wr_en) begin
      case (wb.adr_i)
        4'd0: en_d = wb.dat_i[NCH-1:0];
        4'd1: begin
          clr_valid = wb.dat_i[NCH-1:0];
          clr_ovf   = wb.dat_i[8 +: NCH];
        end
        4'd2: ien_d = wb.dat_i[NCH-1:0];
        default: ;
      endcase
    end
    valid_d = (valid_q & ~clr_valid) | cap_set;
    ovf_d   = (ovf_q & ~clr_ovf) | ovf_set;
  end

  // Read mux samples pre-edge state, so a same-cycle capture reads old data.
  always_comb begin
    dat_d = '0;
    if (access) begin
      case (wb.adr_i)
        4'd0: dat_d = 32'(en_q);
        4'd1: dat_d = status;
        4'd2: dat_d = 32'(ien_q);
        default: begin
          for (int n = 0; n < NCH; n++) begin
            if (wb.adr_i == 4'(8 + n)) dat_d = 32'(per_q[n]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      en_q    <= '0;
      ien_q   <= '0;
      valid_q <= '0;
      ovf_q   <= '0;
      armed_q <= '0;
      for (int n = 0; n < NCH; n++) begin
        cnt_q[n] <= '0;
        per_q[n] <= '0;
      end
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= capture_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      en_q    <= en_d;
      ien_q   <= ien_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      armed_q <= armed_d;
      for (int n = 0; n < NCH; n++) begin
        cnt_q[n] <= cnt_d[n];
        per_q[n] <= per_d[n];
      end
      ack_q   <= access;
      dat_q   <= dat_d;
      irq_q   <= |(valid_d & ien_q);
    end
  end

  assign wb.dat_o = dat_q;
  assign wb.ack_o = ack_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_countcap.sv
// tb/tb_countcap.sv - directed self-checking bench for countcap
module tb_countcap;
  localparam int NCH = 8;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] capture = '0;
  logic           irq;

  countcap_if wb_if ();

  countcap #(.NCH(NCH), .CW(CW)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .wb        (wb_if.slave),
    .capture_i (capture),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int tcnt  = 0;
  bit wave_on [NCH];
  int per_c   [NCH];
  int half_c  [NCH];
  int phase_c [NCH];

  // One cycle: advance to the falling edge and update the wave generators.
  task automatic tick();
    @(negedge clk);
    tcnt++;
    for (int c = 0; c < NCH; c++) begin
      if (wave_on[c]) begin
        capture[c] = (phase_c[c] < half_c[c]);
        phase_c[c] = (phase_c[c] + 1 == per_c[c]) ? 0 : phase_c[c] + 1;
      end
    end
  endtask

  task automatic wait_until(input int t);
    while (tcnt < t) tick();
  endtask

  // Rising edge is driven in the next tick; its index is returned.
  task automatic start_wave(input int c, input int p, output int rise_t);
    capture[c] = 1'b0;
    per_c[c]   = p;
    half_c[c]  = p / 2;
    phase_c[c] = 0;
    wave_on[c] = 1'b1;
    rise_t     = tcnt + 1;
  endtask

  task automatic stop_wave(input int c);
    wave_on[c] = 1'b0;
    capture[c] = 1'b0;
  endtask

  task automatic bus(input bit we, input logic [3:0] adr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic ack_s, output logic irq_s);
    wb_if.cyc_i = 1'b1;
    wb_if.stb_i = 1'b1;
    wb_if.we_i  = we;
    wb_if.adr_i = adr;
    wb_if.dat_i = wd;
    tick();
    rd    = wb_if.dat_o;
    ack_s = wb_if.ack_o;
    irq_s = irq;
    wb_if.cyc_i = 1'b0;
    wb_if.stb_i = 1'b0;
    wb_if.we_i  = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] wd);
    logic [31:0] d;
    logic a, i;
    bus(1'b1, adr, wd, d, a, i);
  endtask

  task automatic rd(input logic [3:0] adr, output logic [31:0] d);
    logic a, i;
    bus(1'b0, adr, 32'h0, d, a, i);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (wb_if.dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h exp=0", wb_if.dat_o); end
    total++; if (wb_if.ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", wb_if.ack_o); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] adr;
      adr = (k == 3) ? 4'd8 : 4'(k);
      rd(adr, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_reg adr=%0d got=%h exp=0", adr, d); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    int a;
    wr(4'd0, 32'h1);
    wr(4'd2, 32'h1);
    start_wave(0, 10, a);
    wait_until(a + 5);
    rd(4'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL basic_arm_status got=%h exp=0", d); end
    rd(4'd8, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL basic_arm_period got=%h exp=0", d); end
    wait_until(a + 12);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_pre got=%b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq got=%b exp=1", irq); end
    rd(4'd8, d);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL basic_period got=%h exp=%h", d, 32'd10); end
    rd(4'd1, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL basic_status got=%h exp=1", d); end
    wr(4'd1, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_clr got=%b exp=0", irq); end
    rd(4'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL basic_status_clr got=%h exp=0", d); end
    wait_until(a + 23);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq_again got=%b exp=1", irq); end
    stop_wave(0);
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int a, b;
    wr(4'd0, 32'h4);
    wr(4'd1, 32'hFFFF);
    start_wave(2, 300, a);
    wait_until(a + 305);
    rd(4'd10, d);
    total++; if (d !== 32'hFF) begin bad++; $display("FAIL ovf_period got=%h exp=ff", d); end
    rd(4'd1, d);
    total++; if (d !== 32'h404) begin bad++; $display("FAIL ovf_status got=%h exp=404", d); end
    stop_wave(2);
    tick();
    start_wave(2, 40, b);
    wait_until(b + 45);
    rd(4'd10, d);
    total++; if (d !== 32'd40) begin bad++; $display("FAIL ovf_period40 got=%h exp=%h", d, 32'd40); end
    rd(4'd1, d);
    total++; if (d !== 32'h404) begin bad++; $display("FAIL ovf_sticky got=%h exp=404", d); end
    wr(4'd1, 32'h400);
    rd(4'd1, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL ovf_clear got=%h exp=4", d); end
    stop_wave(2);
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    logic ack_s, irq_s;
    int a;
    wr(4'd0, 32'h1);
    wr(4'd2, 32'h1);
    wr(4'd1, 32'hFFFF);
    start_wave(0, 12, a);
    wait_until(a + 14);
    rd(4'd8, d);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL sim_read_old got=%h exp=%h", d, 32'd10); end
    wait_until(a + 26);
    bus(1'b1, 4'd1, 32'h1, d, ack_s, irq_s);
    total++; if (irq_s !== 1'b1) begin bad++; $display("FAIL sim_w1c_irq got=%b exp=1", irq_s); end
    rd(4'd1, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL sim_capture_wins got=%h exp=1", d); end
    rd(4'd8, d);
    total++; if (d !== 32'd12) begin bad++; $display("FAIL sim_period12 got=%h exp=%h", d, 32'd12); end
    wait_until(a + 37);
    bus(1'b1, 4'd1, 32'h1, d, ack_s, irq_s);
    total++; if (irq_s !== 1'b0) begin bad++; $display("FAIL sim_early_irq0 got=%b exp=0", irq_s); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL sim_early_irq1 got=%b exp=1", irq); end
    rd(4'd1, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL sim_early_status got=%h exp=1", d); end
    stop_wave(0);
  endtask

  task automatic test_disable();
    logic [31:0] d;
    int a;
    wr(4'd0, 32'h0);
    wr(4'd0, 32'h1);
    start_wave(0, 10, a);
    wait_until(a + 5);
    wr(4'd0, 32'h0);
    wr(4'd0, 32'h1);
    wait_until(a + 14);
    rd(4'd8, d);
    total++; if (d !== 32'd12) begin bad++; $display("FAIL dis_rearm_only got=%h exp=%h", d, 32'd12); end
    wait_until(a + 24);
    rd(4'd8, d);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL dis_capture got=%h exp=%h", d, 32'd10); end
    stop_wave(0);
  endtask

  task automatic test_bus();
    logic [31:0] d;
    logic exp_ack;
    wb_if.cyc_i = 1'b1;
    wb_if.stb_i = 1'b1;
    wb_if.we_i  = 1'b0;
    wb_if.adr_i = 4'd1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_ack = (i % 2 == 0);
      total++; if (wb_if.ack_o !== exp_ack) begin bad++; $display("FAIL bus_ack_%0d got=%b exp=%b", i, wb_if.ack_o, exp_ack); end
      total++; if (wb_if.dat_o !== (exp_ack ? 32'h1 : 32'h0)) begin bad++; $display("FAIL bus_dat_%0d got=%h exp=%h", i, wb_if.dat_o, (exp_ack ? 32'h1 : 32'h0)); end
    end
    wb_if.cyc_i = 1'b0;
    wb_if.stb_i = 1'b0;
    tick();
    wr(4'd8, 32'hDEAD);
    rd(4'd8, d);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL bus_period_ro got=%h exp=%h", d, 32'd10); end
    rd(4'd5, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL bus_unmapped got=%h exp=0", d); end
    wr(4'd0, 32'hFFFFFFFF);
    rd(4'd0, d);
    total++; if (d !== 32'hFF) begin bad++; $display("FAIL bus_enable_mask got=%h exp=ff", d); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL areset_pre_irq got=%b exp=1", irq); end
    wb_if.cyc_i = 1'b1;
    wb_if.stb_i = 1'b1;
    wb_if.we_i  = 1'b0;
    wb_if.adr_i = 4'd1;
    tick();
    total++; if (wb_if.ack_o !== 1'b1) begin bad++; $display("FAIL areset_pre_ack got=%b exp=1", wb_if.ack_o); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (wb_if.dat_o !== 32'h0) begin bad++; $display("FAIL areset_dat got=%h exp=0", wb_if.dat_o); end
    total++; if (wb_if.ack_o !== 1'b0) begin bad++; $display("FAIL areset_ack got=%b exp=0", wb_if.ack_o); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL areset_irq got=%b exp=0", irq); end
    wb_if.cyc_i = 1'b0;
    wb_if.stb_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] adr;
      adr = (k == 3) ? 4'd8 : 4'(k);
      rd(adr, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL areset_reg adr=%0d got=%h exp=0", adr, d); end
    end
  endtask

  initial begin
    wb_if.cyc_i = 1'b0;
    wb_if.stb_i = 1'b0;
    wb_if.we_i  = 1'b0;
    wb_if.adr_i = 4'd0;
    wb_if.dat_i = 32'h0;
    for (int c = 0; c < NCH; c++) begin
      wave_on[c] = 1'b0;
      per_c[c]   = 2;
      half_c[c]  = 1;
      phase_c[c] = 0;
    end
    test_reset();
    test_basic();
    test_overflow();
    test_simultaneous();
    test_disable();
    test_bus();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/countcap.md
Name: countcap

Overview:
- Wishbone-classic slave peripheral that measures the period of rising edges on NCH external inputs. It is the receive-side counterpart to the counter/pulse generator peripheral.
- Each channel counts clock cycles between successive rising edges and latches the result into a readable PERIOD register. It sets a sticky valid flag and, optionally, raises an interrupt.
- Sits on the same Wishbone bus and register map style as the other timer peripherals.

Parameters:
- NCH, 8, number of capture channels (1..8)
- CW, 32, period counter/register width (8..32); register reads are zero-extended to 32 bits

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-low reset
- cyc_i  in  1  Wishbone cycle
- stb_i  in  1  Wishbone strobe
- we_i  in  1  Wishbone write enable
- adr_i  in  4  word address
- dat_i  in  32  write data
- dat_o  out  32  read data (registered)
- ack_o  out  1  Wishbone acknowledge (registered)
- capture_i  in  NCH  asynchronous capture inputs
- irq_o  out  1  interrupt, level, active-high

Behaviour:

Reset:
- rst_i low asynchronously clears all flops.
- Outputs: dat_o=0, ack_o=0, irq_o=0.
- Registers: ENABLE=0, STATUS=0, IRQEN=0, all PERIOD=0, all counters=0, all armed=0, all synchronizers=0.

Register map (adr_i):
- 0 ENABLE RW [NCH-1:0]
- 1 STATUS: [7:0] valid, [15:8] overflow; read returns flags, write-1-to-clear
- 2 IRQEN RW [NCH-1:0]
- 8+n PERIOD[n] RO
- Unmapped or absent-channel addresses read 0; writes to them and to PERIOD are ignored.

Bus:
- ack_o<=1 when cyc_i&stb_i&~ack_o, otherwise 0. This gives a one-cycle ack pulse, one cycle latency, and at most one ack every 2 cycles under continuous strobe.
- dat_o is loaded on the same edge that sets ack_o.
- Writes take effect on that same edge.
- dat_o returns to 0 when ack_o is 0.

Input path:
- Per channel, three flops s1<-capture_i, s2<-s1, s3<-s2. edge = s2 & ~s3.
- An input transition sampled at clock edge k produces a register update at edge k+2.

Channel state (per channel n):
- Disabled (ENABLE[n]=0): counter=0, armed=0. PERIOD and flags are retained.
- Enabled, not armed: counter held at 0. The first edge sets armed=1 with no capture.
- Armed: counter increments each cycle and saturates at 2^CW-1.
- On edge while armed:
  - If counter<2^CW-1: PERIOD<=counter+1 (cycles between edges).
  - Else: PERIOD<=2^CW-1 and overflow[n]<=1.
  - In both cases valid[n]<=1 and counter<=0.
- Minimum measurable period is 2 cycles.

Boundary cases:
- Clearing ENABLE[n] mid-measurement drops armed and the counter on the next edge. Re-enabling requires a fresh arming edge.
- A STATUS W1C in the same cycle as a capture on the same bit: the capture wins and the flag stays 1.
- A PERIOD read in the same cycle as a capture returns the old value.
- Overwrite of an unread PERIOD is allowed. The valid flag simply remains 1 (no separate lost flag).
- irq_o is registered: irq_o <= |(valid_next & IRQEN), where valid_next is the STATUS valid field as updated on the same clock edge (captures and W1C clears applied).
- Writing IRQEN with a pending valid bit raises irq_o one cycle after the write edge.

Test Plan:
- Reset:
  - Assert rst_i=0 mid-operation with valid flags set.
  - -> dat_o, ack_o, irq_o are 0 immediately.
  - -> After release, reads of adr 0/1/2/8 return 0.
- Basic capture:
  - Write ENABLE=0x01 and IRQEN=0x01.
  - Drive ch0 with a square wave of period 10 cycles (5 high/5 low).
  - -> No capture on the first edge.
  - -> After the second edge, PERIOD0=10, STATUS=0x00000001, irq_o=1.
  - Write STATUS=0x1 -> STATUS=0 and irq_o=0 one cycle later, until the next capture.
- Overflow (CW=8):
  - Period-300 input on ch2 with ENABLE=0x04.
  - -> PERIOD2=0xFF, STATUS=0x00000404.
  - A following 40-cycle period -> PERIOD2=40, overflow bit stays set until cleared.
- Simultaneous events:
  - Time a STATUS W1C of bit0 to land on the capture edge -> STATUS bit0 reads 1.
  - Repeat one cycle earlier -> 0 then 1.
- Disable mid-measurement:
  - ENABLE=0 halfway through a period, then ENABLE=1.
  - -> The next edge only arms; PERIOD0 keeps its old value until the following edge captures the correct 10.
- Bus protocol:
  - Hold cyc_i/stb_i high for 6 cycles -> ack_o pulses on alternate cycles.
  - Write 0xDEAD to adr 8 -> PERIOD0 unchanged.
  - Read adr 5 -> 0.
  - Read ENABLE after a 0xFFFFFFFF write with NCH=8 -> 0x000000FF.
